// File: rtl/studio_keypad_array_if.sv
// CPU-side bus for the Studio II keypad front end: OUT strobe, N lines, OUT data
// and the key-select latch read back by the core.
interface studio_keypad_array_if;
    logic       io_out;
    logic [2:0] io_n;
    logic [7:0] io_dout;
    logic [3:0] key_sel;

    modport master (output io_out, output io_n, output io_dout, input key_sel);
    modport slave  (input io_out, input io_n, input io_dout, output key_sel);
endinterface

// File: rtl/studio_keypad_array.sv
// Studio II keypad array: PS/2 make/break + ext_keys key state, OUT-loaded key select, active-low EF per pad.
// Optional minimum press duration enabled by defining KEYPAD_MIN_HOLD_EN.
module studio_keypad_array #(
    parameter int unsigned NUM_PADS     = 2,
    parameter int unsigned KEYS_PER_PAD = 10,
    parameter logic [2:0]  SEL_PORT     = 3'd2,
    parameter int unsigned HOLD_CYCLES  = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic [NUM_PADS*16-1:0] ext_keys,
    studio_keypad_array_if.slave   cpu,
    output logic [NUM_PADS-1:0]    ef_n,
    output logic [NUM_PADS-1:0]    any_key
);
    localparam logic [15:0] KEY_MASK = 16'((33'h1 << KEYS_PER_PAD) - 33'h1);

    logic                   tog_q;
    logic [NUM_PADS*16-1:0] ps2_q, ps2_d;
    logic [3:0]             key_sel_q, key_sel_d;
    logic [NUM_PADS-1:0]    ef_n_q, ef_n_d;
    logic [NUM_PADS-1:0]    any_key_q, any_key_d;

    logic                   evt, accept, map_hit, map_pad, sel_ok;
    logic [3:0]             map_key;
    logic [NUM_PADS*16-1:0] eff;
    logic [15:0]            row;
    logic [3:0]             unused_dout;

`ifdef KEYPAD_MIN_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    logic [NUM_PADS*16-1:0] pend_q, pend_d;
    logic [HOLD_W-1:0]      hold_q [NUM_PADS];
    logic [HOLD_W-1:0]      hold_d [NUM_PADS];
    logic [NUM_PADS-1:0]    reload;
`else
    logic [31:0]            unused_hold;
    assign unused_hold = HOLD_CYCLES;
`endif

    assign unused_dout = cpu.io_dout[7:4];
    assign evt         = ps2_key[10] ^ tog_q;

    always_comb begin
        map_hit = 1'b1;
        map_pad = 1'b0;
        map_key = 4'd0;
        case (ps2_key[7:0])
            8'h16: map_key = 4'd1;   8'h1E: map_key = 4'd2;
            8'h26: map_key = 4'd3;   8'h25: map_key = 4'd4;
            8'h2E: map_key = 4'd5;   8'h36: map_key = 4'd6;
            8'h3D: map_key = 4'd7;   8'h3E: map_key = 4'd8;
            8'h46: map_key = 4'd9;   8'h45: map_key = 4'd0;
            8'h70: begin map_pad = 1'b1; map_key = 4'd0; end
            8'h69: begin map_pad = 1'b1; map_key = 4'd1; end
            8'h72: begin map_pad = 1'b1; map_key = 4'd2; end
            8'h7A: begin map_pad = 1'b1; map_key = 4'd3; end
            8'h6B: begin map_pad = 1'b1; map_key = 4'd4; end
            8'h73: begin map_pad = 1'b1; map_key = 4'd5; end
            8'h74: begin map_pad = 1'b1; map_key = 4'd6; end
            8'h6C: begin map_pad = 1'b1; map_key = 4'd7; end
            8'h75: begin map_pad = 1'b1; map_key = 4'd8; end
            8'h7D: begin map_pad = 1'b1; map_key = 4'd9; end
            default: map_hit = 1'b0;
        endcase
    end

    // Key state next value; with min-hold, breaks inside the hold window become pending.
    always_comb begin
        ps2_d  = ps2_q;
        accept = evt && !ps2_key[8] && map_hit &&
                 (32'(map_key) < KEYS_PER_PAD) && (32'(map_pad) < NUM_PADS);
`ifdef KEYPAD_MIN_HOLD_EN
        pend_d = pend_q;
        hold_d = hold_q;
        reload = '0;
`endif
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            for (int unsigned k = 0; k < 16; k++) begin
                if (accept && 32'(map_pad) == p && 32'(map_key) == k) begin
                    if (ps2_key[9]) begin
                        ps2_d[p*16+k] = 1'b1;
`ifdef KEYPAD_MIN_HOLD_EN
                        pend_d[p*16+k] = 1'b0;
                        reload[p]      = 1'b1;
`endif
                    end else begin
`ifdef KEYPAD_MIN_HOLD_EN
                        if (hold_q[p] != '0) begin
                            if (ps2_q[p*16+k]) pend_d[p*16+k] = 1'b1;
                        end else begin
                            ps2_d[p*16+k] = 1'b0;
                        end
`else
                        ps2_d[p*16+k] = 1'b0;
`endif
                    end
                end
            end
`ifdef KEYPAD_MIN_HOLD_EN
            if (reload[p]) begin
                hold_d[p] = HOLD_W'(HOLD_CYCLES);
            end else if (hold_q[p] != '0) begin
                hold_d[p] = hold_q[p] - 1'b1;
                if (hold_q[p] == HOLD_W'(1)) begin
                    ps2_d[p*16 +: 16]  = ps2_d[p*16 +: 16] & ~pend_d[p*16 +: 16];
                    pend_d[p*16 +: 16] = '0;
                end
            end
`endif
        end
    end

    always_comb begin
        key_sel_d = key_sel_q;
        if (cpu.io_out && cpu.io_n == SEL_PORT) key_sel_d = cpu.io_dout[3:0];
    end

    // Flags are built from the already-registered select and key state.
    always_comb begin
        eff       = (ps2_q | ext_keys) & {NUM_PADS{KEY_MASK}};
        sel_ok    = 32'(key_sel_q) < KEYS_PER_PAD;
        row       = '0;
        ef_n_d    = '1;
        any_key_d = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            row          = eff[p*16 +: 16];
            ef_n_d[p]    = ~(sel_ok & row[key_sel_q]);
            any_key_d[p] = |row;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q     <= 1'b0;
            ps2_q     <= '0;
            key_sel_q <= '0;
            ef_n_q    <= '1;
            any_key_q <= '0;
`ifdef KEYPAD_MIN_HOLD_EN
            pend_q    <= '0;
            hold_q    <= '{default: '0};
`endif
        end else begin
            tog_q     <= ps2_key[10];
            ps2_q     <= ps2_d;
            key_sel_q <= key_sel_d;
            ef_n_q    <= ef_n_d;
            any_key_q <= any_key_d;
`ifdef KEYPAD_MIN_HOLD_EN
            pend_q    <= pend_d;
            hold_q    <= hold_d;
`endif
        end
    end

    assign cpu.key_sel = key_sel_q;
    assign ef_n        = ef_n_q;
    assign any_key     = any_key_q;
endmodule
